// File: rtl/axil_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_arith_pkg
//  Description : Shared definitions for the AXI4-Lite arithmetic array:
//                response codes, register offsets, mode encodings and the
//                address decoder used by both the write and read paths.
//  Ports       : none (package)
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
package axil_arith_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offsets. Lane registers are relative to the channel base (0x10*c);
  // STATUS and INFO are absolute addresses in the top 16-byte slot.
  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'hF0;
  localparam logic [7:0] OFF_INFO   = 8'hF4;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_SADD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Word index of a lane register inside its 16-byte slot (offset >> 2).
  typedef enum logic [1:0] {
    SEL_OPA    = 2'd0,
    SEL_OPB    = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_RESULT = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    TGT_NONE   = 2'd0,
    TGT_LANE   = 2'd1,
    TGT_STATUS = 2'd2,
    TGT_INFO   = 2'd3
  } target_e;

  typedef struct packed {
    target_e  tgt;
    logic [3:0] ch;
    reg_sel_e sel;
  } dec_t;

  // Decodes a word address (byte address >> 2). Anything at or above byte
  // address 0x100, any channel slot >= num_ch and the unused words of the
  // top slot decode to TGT_NONE.
  function automatic dec_t decode_addr(input logic [29:0] word, input int num_ch);
    dec_t d;
    d.tgt = TGT_NONE;
    d.ch  = word[5:2];
    d.sel = reg_sel_e'(word[1:0]);
    if (word[29:6] == '0) begin
      if (word[5:2] == 4'hF) begin
        if ({word[5:0], 2'b00} == OFF_STATUS)    d.tgt = TGT_STATUS;
        else if ({word[5:0], 2'b00} == OFF_INFO) d.tgt = TGT_INFO;
      end else if (int'(word[5:2]) < num_ch) begin
        d.tgt = TGT_LANE;
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_arith_if.sv
`default_nettype none
// ============================================================================
//  Module      : axil_arith_if
//  Description : AXI4-Lite bus bundle for the arithmetic array (s1 port).
//  Ports       : aw*/w*/b*/ar*/r* AXI4-Lite channel signals;
//                modport slave for the peripheral, master for the initiator.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
interface axil_arith_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axil_arith_lane.sv
`default_nettype none
// ============================================================================
//  Module      : axil_arith_lane
//  Description : One add/subtract channel: OPA/OPB/CTRL registers with byte
//                strobe merge, mode datapath and registered RESULT/carry/sat.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_we            commit a write to the register picked by i_sel
//                i_sel           lane register select
//                i_wdata/i_wstrb write data and byte strobes
//                o_opa/o_opb     operand readback
//                o_mode          current mode (CTRL[1:0])
//                o_result        registered result
//                o_carry/o_sat   registered carry/borrow and saturation flags
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module axil_arith_lane
  import axil_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  reg_sel_e                i_sel,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   o_opa,
  output logic [DATA_WIDTH-1:0]   o_opb,
  output mode_e                   o_mode,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic                    o_carry,
  output logic                    o_sat
);

  localparam int c_nbytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  mode_e                 r_mode;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_carry;
  logic                  r_sat;

  logic [DATA_WIDTH-1:0] w_opa_merged;
  logic [DATA_WIDTH-1:0] w_opb_merged;
  mode_e                 w_mode_merged;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_carry;
  logic                  w_sat;

  // Byte-lane merge: unstrobed bytes keep their current contents.
  for (genvar i = 0; i < c_nbytes; i++) begin : g_byte
    assign w_opa_merged[i*8 +: 8] = i_wstrb[i] ? i_wdata[i*8 +: 8] : r_opa[i*8 +: 8];
    assign w_opb_merged[i*8 +: 8] = i_wstrb[i] ? i_wdata[i*8 +: 8] : r_opb[i*8 +: 8];
  end

  // Only CTRL[1:0] is implemented, so byte lane 0 alone controls it.
  assign w_mode_merged = i_wstrb[0] ? mode_e'(i_wdata[1:0]) : r_mode;

  // The extra MSB of w_diff is set exactly when OPA < OPB (unsigned borrow).
  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

  always_comb begin
    w_result = w_sum[DATA_WIDTH-1:0];
    w_carry  = w_sum[DATA_WIDTH];
    w_sat    = 1'b0;
    case (r_mode)
      MODE_SUB: begin
        w_result = w_diff[DATA_WIDTH-1:0];
        w_carry  = w_diff[DATA_WIDTH];
      end
      MODE_SADD: begin
        w_sat = w_sum[DATA_WIDTH];
        if (w_sum[DATA_WIDTH]) w_result = '1;
      end
      default: ;
    endcase
  end

  // The result stage runs one cycle after the commit so it sees the freshly
  // written operand/mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_mode    <= MODE_ADD;
      r_pending <= 1'b0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_pending <= i_we;
      if (i_we) begin
        case (i_sel)
          SEL_OPA:  r_opa  <= w_opa_merged;
          SEL_OPB:  r_opb  <= w_opb_merged;
          SEL_CTRL: r_mode <= w_mode_merged;
          default:  ;
        endcase
      end
      if (r_pending) begin
        r_result <= w_result;
        r_carry  <= w_carry;
        r_sat    <= w_sat;
      end
    end
  end

  assign o_opa    = r_opa;
  assign o_opb    = r_opb;
  assign o_mode   = r_mode;
  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_sat    = r_sat;

endmodule
`default_nettype wire

// File: rtl/axil_arith_array.sv
`default_nettype none
// ============================================================================
//  Module      : axil_arith_array
//  Description : AXI4-Lite slave holding NUM_CH independent add/subtract
//                channels plus STATUS and INFO registers.
//  Ports       : s1_axi_aclk     clock, rising edge
//                s1_axi_aresetn  async active-low reset
//                s1_axi          AXI4-Lite slave bundle (axil_arith_if.slave)
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module axil_arith_array
  import axil_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic        s1_axi_aclk,
  input  logic        s1_axi_aresetn,
  axil_arith_if.slave s1_axi
);

  localparam logic [31:0] c_info_word = {16'h0000, 8'(DATA_WIDTH), 8'(NUM_CH)};

  // Write side holding registers and response.
  logic                    r_ready_en;
  logic                    r_aw_held;
  logic [ADDR_WIDTH-1:0]   r_aw_addr;
  logic                    r_w_held;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [DATA_WIDTH/8-1:0] r_w_strb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;

  // Read side.
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_b_hs;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_commit;
  logic                    w_wr_ok;
  dec_t                    w_wdec;
  dec_t                    w_rdec;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [1:0]              w_rd_resp;
  logic [31:0]             w_status;

  logic [DATA_WIDTH-1:0]   w_opa    [NUM_CH];
  logic [DATA_WIDTH-1:0]   w_opb    [NUM_CH];
  mode_e                   w_mode   [NUM_CH];
  logic [DATA_WIDTH-1:0]   w_result [NUM_CH];
  logic [NUM_CH-1:0]       w_carry;
  logic [NUM_CH-1:0]       w_sat;

  // r_ready_en keeps every ready low while reset is asserted and lets them
  // rise on the first edge after release.
  assign s1_axi.awready = r_ready_en && !r_aw_held && !r_bvalid;
  assign s1_axi.wready  = r_ready_en && !r_w_held && !r_bvalid;
  assign s1_axi.arready = r_ready_en && !r_rvalid;
  assign s1_axi.bvalid  = r_bvalid;
  assign s1_axi.bresp   = r_bresp;
  assign s1_axi.rvalid  = r_rvalid;
  assign s1_axi.rresp   = r_rresp;
  assign s1_axi.rdata   = r_rdata;

  assign w_aw_hs = s1_axi.awvalid && s1_axi.awready;
  assign w_w_hs  = s1_axi.wvalid && s1_axi.wready;
  assign w_b_hs  = r_bvalid && s1_axi.bready;
  assign w_ar_hs = s1_axi.arvalid && s1_axi.arready;
  assign w_r_hs  = r_rvalid && s1_axi.rready;

  // bvalid blocks a second commit of the same held pair.
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;

  assign w_wdec  = decode_addr(30'(r_aw_addr >> 2), NUM_CH);
  assign w_rdec  = decode_addr(30'(s1_axi.araddr >> 2), NUM_CH);
  assign w_wr_ok = (w_wdec.tgt == TGT_LANE) && (w_wdec.sel != SEL_RESULT);

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_held   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      r_ready_en <= 1'b1;

      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s1_axi.awaddr;
      end else if (w_b_hs) begin
        r_aw_held <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s1_axi.wdata;
        r_w_strb <= s1_axi.wstrb;
      end else if (w_b_hs) begin
        r_w_held <= 1'b0;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    axil_arith_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk      (s1_axi_aclk),
      .rst_n    (s1_axi_aresetn),
      .i_we     (w_commit && w_wr_ok && (w_wdec.ch == 4'(c))),
      .i_sel    (w_wdec.sel),
      .i_wdata  (r_w_data),
      .i_wstrb  (r_w_strb),
      .o_opa    (w_opa[c]),
      .o_opb    (w_opb[c]),
      .o_mode   (w_mode[c]),
      .o_result (w_result[c]),
      .o_carry  (w_carry[c]),
      .o_sat    (w_sat[c])
    );
  end

  always_comb begin
    w_status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_status[c]      = w_carry[c];
      w_status[16 + c] = w_sat[c];
    end
  end

  // Read mux, sampled into r_rdata on the AR handshake.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_rdec.tgt)
      TGT_LANE: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_rdec.ch == 4'(c)) begin
            case (w_rdec.sel)
              SEL_OPA:  w_rd_data = w_opa[c];
              SEL_OPB:  w_rd_data = w_opb[c];
              SEL_CTRL: w_rd_data = {{(DATA_WIDTH-2){1'b0}}, w_mode[c]};
              default:  w_rd_data = w_result[c];
            endcase
          end
        end
      end
      TGT_STATUS: w_rd_data = DATA_WIDTH'(w_status);
      TGT_INFO:   w_rd_data = DATA_WIDTH'(c_info_word);
      default:    w_rd_resp = RESP_SLVERR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_arith_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_arith_array
//  Description : Self-checking bench for axil_arith_array. Expected write
//                responses and read data are queued when a transaction is
//                issued and compared by a monitor when the DUT responds.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module tb_axil_arith_array;
  import axil_arith_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NCH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_arith_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_arith_array #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH)
  ) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (rst_n),
    .s1_axi         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  string       rq_tag  [$];
  logic [1:0]  bq_resp [$];
  string       bq_tag  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed B or R beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bvalid && bus.bready) begin
        if (bq_resp.size() == 0) begin
          check("unexpected_b", 32'd1, 32'd0);
        end else begin
          check({bq_tag[0], "_bresp"}, 32'(bus.bresp), 32'(bq_resp[0]));
          void'(bq_resp.pop_front());
          void'(bq_tag.pop_front());
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (rq_data.size() == 0) begin
          check("unexpected_r", 32'd1, 32'd0);
        end else begin
          check({rq_tag[0], "_rdata"}, bus.rdata, rq_data[0]);
          check({rq_tag[0], "_rresp"}, 32'(bus.rresp), 32'(rq_resp[0]));
          void'(rq_data.pop_front());
          void'(rq_resp.pop_front());
          void'(rq_tag.pop_front());
        end
      end
    end
  end

  task automatic wait_b_drain(input string tag);
    for (int i = 0; i < 50 && bq_resp.size() != 0; i++) @(posedge clk);
    if (bq_resp.size() != 0) begin
      check({tag, "_b_timeout"}, 32'd1, 32'd0);
      bq_resp.delete();
      bq_tag.delete();
    end
  endtask

  task automatic wait_r_drain(input string tag);
    for (int i = 0; i < 50 && rq_data.size() != 0; i++) @(posedge clk);
    if (rq_data.size() != 0) begin
      check({tag, "_r_timeout"}, 32'd1, 32'd0);
      rq_data.delete();
      rq_resp.delete();
      rq_tag.delete();
    end
  endtask

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] resp, input string tag);
    logic aw_go, w_go;
    bq_resp.push_back(resp);
    bq_tag.push_back(tag);
    @(posedge clk); #1;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d;  bus.wstrb = s; bus.wvalid = 1'b1;
    for (int i = 0; i < 50 && (bus.awvalid || bus.wvalid); i++) begin
      @(negedge clk);
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
    end
    if (bus.awvalid || bus.wvalid) begin
      check({tag, "_aw_w_timeout"}, 32'd1, 32'd0);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
    end
    wait_b_drain(tag);
  endtask

  task automatic axi_rd(input logic [7:0] a, input logic [31:0] exp, input logic [1:0] resp,
                        input string tag);
    logic ar_go;
    rq_data.push_back(exp);
    rq_resp.push_back(resp);
    rq_tag.push_back(tag);
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && bus.arvalid; i++) begin
      @(negedge clk);
      ar_go = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (ar_go) bus.arvalid = 1'b0;
    end
    if (bus.arvalid) begin
      check({tag, "_ar_timeout"}, 32'd1, 32'd0);
      bus.arvalid = 1'b0;
    end
    wait_r_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rexp;
    logic        rmode;

    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_awready", 32'(bus.awready), 32'd1);
    check("post_rst_arready", 32'(bus.arready), 32'd1);

    // Channel 0 add
    axi_wr(8'h00, 32'd39, 4'hF, RESP_OKAY, "c0_opa");
    axi_wr(8'h04, 32'd40, 4'hF, RESP_OKAY, "c0_opb");
    axi_rd(8'h0C, 32'd79, RESP_OKAY, "c0_result");
    axi_rd(8'hF0, 32'h0, RESP_OKAY, "status_a");

    // Channel 1 subtract with borrow
    axi_wr(8'h18, 32'd1, 4'hF, RESP_OKAY, "c1_ctrl");
    axi_wr(8'h10, 32'd5, 4'hF, RESP_OKAY, "c1_opa");
    axi_wr(8'h14, 32'd7, 4'hF, RESP_OKAY, "c1_opb");
    axi_rd(8'h1C, 32'hFFFF_FFFE, RESP_OKAY, "c1_result");
    axi_rd(8'h0C, 32'd79, RESP_OKAY, "c0_unchanged");
    axi_rd(8'hF0, 32'h0000_0002, RESP_OKAY, "status_b");
    axi_rd(8'h18, 32'd1, RESP_OKAY, "c1_ctrl_rb");

    // Channel 2 saturating add, then plain add of the same operands
    axi_wr(8'h28, 32'd2, 4'hF, RESP_OKAY, "c2_ctrl");
    axi_wr(8'h20, 32'hFFFF_FFF0, 4'hF, RESP_OKAY, "c2_opa");
    axi_wr(8'h24, 32'h0000_0020, 4'hF, RESP_OKAY, "c2_opb");
    axi_rd(8'h2C, 32'hFFFF_FFFF, RESP_OKAY, "c2_sat_result");
    axi_rd(8'hF0, 32'h0004_0006, RESP_OKAY, "status_c");
    axi_wr(8'h28, 32'd0, 4'hF, RESP_OKAY, "c2_ctrl_add");
    axi_rd(8'h2C, 32'h0000_0010, RESP_OKAY, "c2_add_result");
    axi_rd(8'hF0, 32'h0000_0006, RESP_OKAY, "status_d");

    // W leads AW by 3 cycles, bready held low for 4 cycles, byte-0 strobe
    bus.bready = 1'b0;
    @(posedge clk); #1;
    bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
    @(negedge clk);
    check("early_w_wready", 32'(bus.wready), 32'd1);
    @(posedge clk); #1 bus.wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.awaddr = 8'h30; bus.awvalid = 1'b1;
    bq_resp.push_back(RESP_OKAY);
    bq_tag.push_back("strb_wr");
    @(negedge clk);
    check("w_held_wready", 32'(bus.wready), 32'd0);
    check("late_aw_awready", 32'(bus.awready), 32'd1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("bhold_bvalid",  32'(bus.bvalid),  32'd1);
      check("bhold_awready", 32'(bus.awready), 32'd0);
      check("bhold_wready",  32'(bus.wready),  32'd0);
    end
    @(posedge clk); #1 bus.bready = 1'b1;
    wait_b_drain("strb_wr");
    @(negedge clk);
    check("strb_bvalid_drop", 32'(bus.bvalid), 32'd0);
    axi_rd(8'h30, 32'h0000_00DD, RESP_OKAY, "c3_opa_strb");
    axi_rd(8'h3C, 32'h0000_00DD, RESP_OKAY, "c3_result");

    // Error responses and decode boundaries
    axi_wr(8'h0C, 32'h55, 4'hF, RESP_SLVERR, "wr_result");
    axi_rd(8'h0C, 32'd79, RESP_OKAY, "c0_result_kept");
    axi_wr(8'hE0, 32'h1, 4'hF, RESP_SLVERR, "wr_unmapped");
    axi_rd(8'hE0, 32'h0, RESP_SLVERR, "rd_unmapped");
    axi_wr(8'hF0, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, "wr_status");
    axi_rd(8'hF0, 32'h0000_0006, RESP_OKAY, "status_kept");
    axi_rd(8'hF4, 32'h0000_2004, RESP_OKAY, "info");
    axi_wr(8'h00, 32'hFFFF_FFFF, 4'h0, RESP_OKAY, "wr_nostrb");
    axi_rd(8'h00, 32'd39, RESP_OKAY, "c0_opa_kept");
    axi_rd(8'h0D, 32'd79, RESP_OKAY, "unaligned_rd");

    // Random add/subtract on channel 0
    for (int k = 0; k < 4; k++) begin
      ra    = $urandom;
      rb    = $urandom;
      rmode = k[0];
      rexp  = rmode ? (ra - rb) : (ra + rb);
      axi_wr(8'h08, {31'd0, rmode}, 4'hF, RESP_OKAY, "rnd_ctrl");
      axi_wr(8'h00, ra, 4'hF, RESP_OKAY, "rnd_opa");
      axi_wr(8'h04, rb, 4'hF, RESP_OKAY, "rnd_opb");
      axi_rd(8'h0C, rexp, RESP_OKAY, "rnd_result");
    end

    // Reset with AW held and a read response pending
    bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid",  32'(bus.rvalid),  32'd1);
    check("pre_rst_awready", 32'(bus.awready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_awready", 32'(bus.awready), 32'd0);
    check("mid_rst_wready",  32'(bus.wready),  32'd0);
    check("mid_rst_arready", 32'(bus.arready), 32'd0);
    check("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("mid_rst_rdata",   bus.rdata,        32'd0);
    check("mid_rst_rresp",   32'(bus.rresp),   32'd0);
    @(posedge clk); #1 rst_n = 1'b1; bus.rready = 1'b1;
    repeat (2) @(posedge clk);
    axi_rd(8'h00, 32'h0, RESP_OKAY, "post_rst_opa");
    axi_rd(8'h2C, 32'h0, RESP_OKAY, "post_rst_c2_result");
    axi_rd(8'hF0, 32'h0, RESP_OKAY, "post_rst_status");
    axi_wr(8'h14, 32'd3, 4'hF, RESP_OKAY, "post_rst_c1_opb");
    axi_rd(8'h00, 32'h0, RESP_OKAY, "post_rst_no_stale_aw");
    axi_rd(8'h1C, 32'd3, RESP_OKAY, "post_rst_c1_result");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_arith_array.md
# axil_arith_array

Parametrised AXI4-Lite slave holding NUM_CH independent add/subtract channels, successor to the single-channel AXI-Lite adder. Each channel has two operand registers, a mode register and a registered result with carry/overflow status; software writes operands over the s1 AXI-Lite port and reads results back. Sits on the s1 control bus as a memory-mapped peripheral, one clock domain.

## Interface
- DATA_WIDTH, 32, register/data width; multiple of 8
- ADDR_WIDTH, 8, byte address width; must satisfy 16*NUM_CH ≤ 0xF0
- NUM_CH, 4, channel count, 1..15
- s1_axi_aclk  in  1  clock, all logic on rising edge
- s1_axi_aresetn  in  1  reset, asynchronous assert, active-low
- s1_axi_awaddr / awvalid / awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s1_axi_wdata / wstrb / wvalid / wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- s1_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response
- s1_axi_araddr / arvalid / arready  in/in/out  ADDR_WIDTH/1/1  read address
- s1_axi_rdata / rresp / rvalid / rready  out/out/out/in  DATA_WIDTH/2/1/1  read data

## Operation
- Map, channel c base 0x10*c: +0x0 OPA RW, +0x4 OPB RW, +0x8 CTRL RW (bits[1:0] mode, rest read 0), +0xC RESULT RO. 0xF0 STATUS RO: bit c = carry/borrow of channel c, bit 16+c = saturation hit. 0xF4 INFO RO: [7:0]=NUM_CH, [15:8]=DATA_WIDTH.
- Modes: 00 RESULT=A+B mod 2^DATA_WIDTH, carry = bit DATA_WIDTH of sum; 01 RESULT=A−B mod 2^DATA_WIDTH, carry = borrow (A<B unsigned); 10 unsigned saturating add, RESULT=all-ones on carry, sat flag set; 11 reserved, behaves as 00.
- Any committed write to OPA/OPB/CTRL of channel c recomputes that channel; other channels unchanged.
- wstrb: byte lane i written only if wstrb[i]; wstrb=0 is a legal no-op returning OKAY.
- Word-aligned decode: awaddr/araddr[1:0] ignored.
- Responses: OKAY=00; SLVERR=10 for unmapped address or write to RESULT/STATUS/INFO (no state change). Reads of unmapped addresses return rdata=0, SLVERR.

## Timing
- Reset: all registers 0; awready, wready, arready, bvalid, rvalid =0; bresp, rresp, rdata =0. awready/wready/arready go high the first cycle after deassertion.
- AW and W accepted independently, either order or same cycle; each has a one-entry holding register; awready=!aw_held && !bvalid, wready=!w_held && !bvalid.
- Commit on the first cycle both are held: register update and bvalid rise on the same edge; bvalid/bresp hold until bready; holding regs clear on the bvalid&&bready edge.
- RESULT/STATUS update one cycle after commit. A read whose AR handshake occurs in the commit cycle returns the old RESULT.
- Read: arready=!rvalid; rvalid and rdata registered one cycle after AR handshake; rdata/rresp stable until rready. Back-to-back reads: one per two cycles when rready held high.
- Simultaneous read and write proceed in parallel; no arbitration stalls.
- Reset mid-transaction: pending AW/W, bvalid and rvalid dropped; no partial register write.

## Structure
- Package axil_arith_pkg: RESP_OKAY/RESP_SLVERR, register offsets (OPA, OPB, CTRL, RESULT, STATUS, INFO), mode encodings.
- Sub-module axil_arith_lane: one channel's OPA/OPB/CTRL regs, strobe merge, mode datapath, registered RESULT/carry/sat; generated NUM_CH times. Top holds AXI handshakes, decode and read mux.

## Test plan
- Reset then write ch0 OPA=39, OPB=40 (mode 00), read 0x0C -> 79, OKAY; STATUS bit0=0.
- ch1 mode 01, OPA=5, OPB=7; read 0x1C -> 0xFFFFFFFE, STATUS bit1=1; ch0 RESULT still 79.
- ch2 mode 10, OPA=0xFFFFFFF0, OPB=0x20 -> RESULT 0xFFFFFFFF, STATUS bits 2 and 18 set; mode 00 same operands -> 0x10.
- W presented 3 cycles before AW, bready low 4 cycles -> single commit, bvalid held, awready/wready low until bready; wstrb=0x1 writing 0xAABBCCDD over 0 -> OPA=0x000000DD.
- Write to 0x0C and to 0xE0, read 0xE0 -> SLVERR each, no register change, rdata 0; read 0xF4 -> 0x00002004.
- Assert aresetn low with AW held and rvalid pending -> all outputs 0 next edge; post-reset read 0x00 -> 0.
